// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues one req/ack read per PC, loads the IF/ID register,
// and parks a word in a one-entry skid buffer while decode is stalled.
module if_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              flush,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic              fetch_fault,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic              drop;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic              can_load;
  logic [ADDR_W-1:0] req_plus4;
  logic [ADDR_W-1:0] skid_plus4;

  // Memory handshake: imem_req rises with imem_addr valid and both stay constant until
  // the cycle imem_ack is seen high; that cycle completes the transfer and carries
  // imem_rdata. The request is never withdrawn early; a flush only marks it for discard.
  assign imem_addr  = req_addr;
  assign pc_plus4   = pc_addr + FOUR;
  assign req_plus4  = req_addr + FOUR;
  assign skid_plus4 = skid_pc + FOUR;
  assign can_load   = !ifid_valid || !id_stall;
  assign state_dbg  = state;
  assign pc_advance = !reset && (state == WAIT) && imem_ack && !drop && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      imem_req      <= 1'b0;
      req_addr      <= '0;
      drop          <= 1'b0;
      skid_instr    <= NOP_INSTR;
      skid_pc       <= '0;
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      fetch_fault   <= 1'b0;
    end else begin
      if (ifid_valid && !id_stall)
        ifid_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && !fetch_fault) begin
            if (pc_addr[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              if (can_load) begin
                ifid_valid    <= 1'b1;
                ifid_instr    <= NOP_INSTR;
                ifid_pc       <= pc_addr;
                ifid_pc_plus4 <= pc_plus4;
              end
            end else begin
              req_addr <= pc_addr;
              imem_req <= 1'b1;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            drop     <= 1'b0;
            if (drop || flush) begin
              state <= IDLE;
            end else if (can_load) begin
              ifid_valid    <= 1'b1;
              ifid_instr    <= imem_rdata;
              ifid_pc       <= req_addr;
              ifid_pc_plus4 <= req_plus4;
              state         <= IDLE;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= req_addr;
              state      <= HOLD;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (flush) begin
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            state      <= IDLE;
          end else if (!id_stall) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= skid_instr;
            ifid_pc       <= skid_pc;
            ifid_pc_plus4 <= skid_plus4;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A redirect squashes whatever IF/ID holds and clears a pending fault.
      if (flush) begin
        ifid_valid  <= 1'b0;
        ifid_instr  <= NOP_INSTR;
        fetch_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed walk through the fetch scenarios followed by random traffic, all checked
// against a transaction-level model and an in-order scoreboard of delivered words.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic [31:0] pc_plus4;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        flush;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        fetch_fault;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an outstanding fetch record, a skid queue, the IF/ID contents.
  bit          m_pend = 0;
  bit          m_drop = 0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_skid[$];
  bit          m_ifv = 0;
  logic [31:0] m_ifi = NOP;
  logic [31:0] m_ifp = '0;
  logic [31:0] m_ifp4 = '0;
  bit          m_fault = 0;
  bit          last_adv = 0;
  logic [31:0] exp_q[$];
  logic [31:0] t2_word;
  logic [31:0] tgt;

  if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_plus4(pc_plus4),
    .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_stall(id_stall), .flush(flush),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .fetch_fault(fetch_fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_load(input logic [31:0] instr, input logic [31:0] pc);
    m_ifv  = 1;
    m_ifi  = instr;
    m_ifp  = pc;
    m_ifp4 = pc + 32'd4;
  endtask

  task automatic model_step();
    bit can_load;
    can_load = !m_ifv || !id_stall;
    if (reset) begin
      m_pend = 0; m_drop = 0; m_addr = '0; m_skid.delete();
      m_ifv = 0; m_ifi = NOP; m_ifp = '0; m_ifp4 = '0; m_fault = 0;
      exp_q.delete();
      return;
    end
    if (m_ifv && !id_stall) m_ifv = 0;
    if (m_pend) begin
      if (imem_ack) begin
        m_pend = 0;
        if (m_drop || flush) m_drop = 0;
        else begin
          exp_q.push_back(imem_rdata);
          if (can_load) m_load(imem_rdata, m_addr);
          else m_skid.push_back({imem_rdata, m_addr});
        end
      end else if (flush) m_drop = 1;
    end else if (m_skid.size() != 0) begin
      if (flush) m_skid.delete();
      else if (!id_stall) begin
        m_load(m_skid[0][63:32], m_skid[0][31:0]);
        void'(m_skid.pop_front());
      end
    end else if (!flush && !m_fault) begin
      if (pc_addr[1:0] != 2'b00) begin
        m_fault = 1;
        if (can_load) begin
          m_load(NOP, pc_addr);
          exp_q.push_back(NOP);
        end
      end else begin
        m_pend = 1;
        m_addr = pc_addr;
      end
    end
    if (flush) begin
      m_ifv = 0; m_ifi = NOP; m_fault = 0;
      exp_q.delete();
    end
  endtask

  // One clock: check combinational outputs and consumption, step the model, check state.
  task automatic cycle();
    bit exp_adv;
    #1;
    exp_adv = !reset && m_pend && imem_ack && !m_drop && !flush;
    last_adv = exp_adv;
    chk(32'(pc_advance), 32'(exp_adv), "pc_advance");
    chk(pc_plus4, pc_addr + 32'd4, "pc_plus4");
    if (!reset && m_ifv && !id_stall) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=%h expected=<queued word>", ifid_instr);
      end
      if (exp_q.size() != 0) chk(ifid_instr, exp_q.pop_front(), "sb_consumed");
    end
    @(posedge clk);
    model_step();
    #1;
    chk(32'(imem_req), 32'(m_pend), "imem_req");
    if (m_pend) chk(imem_addr, m_addr, "imem_addr");
    chk(32'(ifid_valid), 32'(m_ifv), "ifid_valid");
    chk(ifid_instr, m_ifi, "ifid_instr");
    chk(ifid_pc, m_ifp, "ifid_pc");
    chk(ifid_pc_plus4, m_ifp4, "ifid_pc_plus4");
    chk(32'(fetch_fault), 32'(m_fault), "fetch_fault");
  endtask

  initial begin
    reset = 1; pc_addr = 32'h00400000; imem_ack = 0; imem_rdata = '0;
    id_stall = 0; flush = 0;
    cycle(); cycle();
    chk(32'(imem_req), 32'd0, "rst_req");
    chk(32'(ifid_valid), 32'd0, "rst_valid");
    chk(ifid_instr, NOP, "rst_instr");
    chk(ifid_pc_plus4, 32'd0, "rst_pc4");

    // Zero-wait fetch.
    reset = 0;
    cycle();
    chk(imem_addr, 32'h00400000, "t1_addr");
    imem_ack = 1; imem_rdata = 32'h20080005;
    #1 chk(32'(pc_advance), 32'd1, "t1_adv");
    cycle();
    chk(ifid_instr, 32'h20080005, "t1_instr");
    chk(ifid_pc, 32'h00400000, "t1_pc");
    chk(ifid_pc_plus4, 32'h00400004, "t1_pc4");

    // Three wait states while decode stalls.
    imem_ack = 0; id_stall = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1 chk(32'(pc_advance), 32'd0, "t2_adv_wait");
      cycle();
      chk(32'(imem_req), 32'd1, "t2_req");
      chk(imem_addr, 32'h00400000, "t2_addr");
      chk(32'(ifid_valid), 32'd1, "t2_valid_held");
    end
    t2_word = $urandom;
    id_stall = 0; imem_ack = 1; imem_rdata = t2_word;
    #1 chk(32'(pc_advance), 32'd1, "t2_adv_ack");
    cycle();
    chk(ifid_instr, t2_word, "t2_instr");

    // Ack during stall parks the word in the skid buffer.
    imem_ack = 0; id_stall = 1; pc_addr = 32'h00400004;
    cycle();
    imem_ack = 1; imem_rdata = 32'h8C090000;
    cycle();
    chk(32'(imem_req), 32'd0, "t3_hold_req");
    chk(ifid_instr, t2_word, "t3_ifid_held");
    imem_ack = 0;
    cycle();
    chk(32'(imem_req), 32'd0, "t3_hold_req2");
    id_stall = 0;
    cycle();
    chk(ifid_instr, 32'h8C090000, "t3_skid_out");
    pc_addr = 32'h00400008;
    cycle();
    chk(32'(imem_req), 32'd1, "t3_next_req");

    // Flush in WAIT, late ack is discarded.
    flush = 1;
    cycle();
    flush = 0; pc_addr = 32'h00400100;
    cycle();
    imem_ack = 1; imem_rdata = 32'hDEADBEEF;
    #1 chk(32'(pc_advance), 32'd0, "t4_adv_dropped");
    cycle();
    chk(32'(ifid_valid), 32'd0, "t4_valid");
    imem_ack = 0;
    cycle();
    chk(imem_addr, 32'h00400100, "t4_redirect_addr");
    imem_ack = 1; imem_rdata = 32'h00000013;
    cycle();
    imem_ack = 0;

    // Misaligned PC fault, cleared by a flush.
    pc_addr = 32'h00400002;
    cycle();
    chk(32'(fetch_fault), 32'd1, "t5_fault");
    chk(32'(ifid_valid), 32'd1, "t5_nop_valid");
    chk(ifid_instr, NOP, "t5_nop");
    cycle();
    chk(32'(imem_req), 32'd0, "t5_no_req");
    flush = 1; pc_addr = 32'h00400100;
    cycle();
    chk(32'(fetch_fault), 32'd0, "t5_fault_clr");
    flush = 0;
    cycle();
    chk(32'(imem_req), 32'd1, "t5_resume");

    // Reset mid-request, then PC wraparound.
    reset = 1;
    cycle();
    chk(32'(imem_req), 32'd0, "t6_req");
    chk(32'(ifid_valid), 32'd0, "t6_valid");
    reset = 0; pc_addr = 32'hFFFFFFFC;
    #1 chk(pc_plus4, 32'h00000000, "t6_wrap");
    cycle();
    imem_ack = 1; imem_rdata = $urandom;
    cycle();
    chk(ifid_pc_plus4, 32'h00000000, "t6_ifid_wrap");
    imem_ack = 0;

    // Random traffic with the PC register modelled in the bench.
    pc_addr = 32'h00400000;
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      id_stall   = ($urandom_range(0, 99) < 30);
      flush      = ($urandom_range(0, 99) < 8);
      imem_ack   = m_pend && ($urandom_range(0, 2) == 0);
      imem_rdata = $urandom;
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      cycle();
      if (reset) pc_addr = 32'h00400000;
      else if (flush) pc_addr = tgt;
      else if (last_adv) pc_addr = pc_addr + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
